// File: rtl/hilo_mult_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : hilo_mult_sequencer_if
// Brief    : EX-stage request/response bundle for the HI/LO multiply sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface hilo_mult_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             HiWrite;
  logic             LoWrite;
  logic [WIDTH-1:0] WriteData;
  logic             HiLoRead;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             Busy;
  logic             Done;
  logic             Stall;

  modport master (
    output Start, Op, A, B, HiWrite, LoWrite, WriteData, HiLoRead,
    input  Hi, Lo, Busy, Done, Stall
  );

  modport slave (
    input  Start, Op, A, B, HiWrite, LoWrite, WriteData, HiLoRead,
    output Hi, Lo, Busy, Done, Stall
  );
endinterface
`default_nettype wire

// File: rtl/hilo_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hilo_mult_sequencer
// Brief    : HI/LO owner; radix-2 shift-add mult/multu/madd/msub plus mthi/mtlo.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  hilo_mult_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_MADD  = 2'b10;
  localparam logic [1:0] OP_MSUB  = 2'b11;

  logic [1:0]         state_q,  state_d;
  logic [1:0]         op_q,     op_d;
  logic [WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               neg_q,    neg_d;
  logic [2*WIDTH-1:0] p_q,      p_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   hi_q,     hi_d;
  logic [WIDTH-1:0]   lo_q,     lo_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_acc;

  // Magnitudes as unsigned values; the most negative input maps onto itself.
  assign w_abs_a  = bus.A[WIDTH-1] ? (-bus.A) : bus.A;
  assign w_abs_b  = bus.B[WIDTH-1] ? (-bus.B) : bus.B;

  assign w_addend = mplier_q[0] ? mcand_q : '0;
  assign w_sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_prod   = neg_q ? (-p_q) : p_q;
  assign w_acc    = {hi_q, lo_q};

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          op_d = bus.Op;
          if (bus.Op == OP_MULTU) begin
            mcand_d  = bus.A;
            mplier_d = bus.B;
            neg_d    = 1'b0;
          end else begin
            mcand_d  = w_abs_a;
            mplier_d = w_abs_b;
            neg_d    = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
          end
          p_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_MUL;
        end else begin
          if (bus.HiWrite) hi_d = bus.WriteData;
          if (bus.LoWrite) lo_d = bus.WriteData;
        end
      end

      S_MUL: begin
        // Carry out of the upper-half add becomes the new MSB after the shift.
        p_d      = {w_sum, p_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIN;
      end

      S_FIN: begin
        case (op_q)
          OP_MADD:  {hi_d, lo_d} = w_acc + w_prod;
          OP_MSUB:  {hi_d, lo_d} = w_acc - w_prod;
          OP_MULT,
          OP_MULTU: {hi_d, lo_d} = w_prod;
          default:  {hi_d, lo_d} = w_prod;
        endcase
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MULT;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.Hi    = hi_q;
  assign bus.Lo    = lo_q;
  assign bus.Busy  = busy_q;
  assign bus.Done  = done_q;
  assign bus.Stall = busy_q & (bus.Start | bus.HiWrite | bus.LoWrite | bus.HiLoRead);

endmodule
`default_nettype wire

// File: tb/tb_hilo_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_mult_sequencer
// Brief    : Vector table plus hand sequences for the HI/LO multiply sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_mult_sequencer;

  logic Clk;
  logic Reset;

  hilo_mult_sequencer_if #(.WIDTH(32)) bus ();

  hilo_mult_sequencer #(.WIDTH(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        preset;
    logic [31:0] hi0;
    logic [31:0] lo0;
    logic        use_model;
    logic [63:0] exp;
  } vec_t;

  vec_t        vecs[12];
  logic [63:0] exp_q[$];
  logic [63:0] acc_m;
  int          n_pass;
  int          n_total;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req)
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    else
      n_pass++;
  endtask

  function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
    logic [63:0] p;
    if (op == 2'b01) p = {32'b0, a} * {32'b0, b};
    else             p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
    case (op)
      2'b10:   return acc + p;
      2'b11:   return acc - p;
      default: return p;
    endcase
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_hl(input logic hw, input logic lw, input logic [31:0] d);
    bus.HiWrite   = hw;
    bus.LoWrite   = lw;
    bus.WriteData = d;
    tick();
    bus.HiWrite   = 1'b0;
    bus.LoWrite   = 1'b0;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    tick();
    bus.Start = 1'b0;
  endtask

  // Called right after edge 0; follows Busy/Done to completion and checks the result.
  task automatic finish_op(input string tag);
    int          edges;
    int          busy_cnt;
    logic [63:0] req;
    edges    = 0;
    busy_cnt = bus.Busy ? 1 : 0;
    while (!bus.Done && edges < 100) begin
      tick();
      edges++;
      if (bus.Busy) busy_cnt++;
    end
    chk({tag, " done_edge"}, 64'(edges), 64'd33);
    chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    if (exp_q.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 64'd1, 64'd0);
    end else begin
      req = exp_q.pop_front();
      chk({tag, " hi"}, {32'b0, bus.Hi}, {32'b0, req[63:32]});
      chk({tag, " lo"}, {32'b0, bus.Lo}, {32'b0, req[31:0]});
    end
    tick();
    chk({tag, " done_fall"}, {63'b0, bus.Done}, 64'd0);
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    Reset         = 1'b1;
    bus.Start     = 1'b0;
    bus.Op        = 2'b00;
    bus.A         = '0;
    bus.B         = '0;
    bus.HiWrite   = 1'b0;
    bus.LoWrite   = 1'b0;
    bus.WriteData = '0;
    bus.HiLoRead  = 1'b0;

    vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'd7,        1'b0, 32'h0, 32'h0, 1'b0, 64'hFFFFFFFF_FFFFFFEB};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 1'b0, 64'hFFFFFFFE_00000001};
    vecs[2]  = '{2'b00, 32'h80000000, 32'h80000000, 1'b0, 32'h0, 32'h0, 1'b0, 64'h40000000_00000000};
    vecs[3]  = '{2'b10, 32'd2,        32'd3,        1'b1, 32'h1, 32'h0, 1'b0, 64'h00000001_00000006};
    vecs[4]  = '{2'b11, 32'd1,        32'd7,        1'b0, 32'h0, 32'h0, 1'b0, 64'h00000000_FFFFFFFF};
    vecs[5]  = '{2'b11, 32'd1,        32'd1,        1'b1, 32'h0, 32'h0, 1'b0, 64'hFFFFFFFF_FFFFFFFF};
    vecs[6]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 1'b0, 64'h00000000_7FFFFFFF};
    vecs[7]  = '{2'b01, 32'h80000000, 32'd2,        1'b0, 32'h0, 32'h0, 1'b0, 64'h00000001_00000000};
    for (int i = 8; i < 12; i++)
      vecs[i] = '{2'(i - 8), $urandom, $urandom, 1'b0, 32'h0, 32'h0, 1'b1, 64'h0};

    repeat (2) tick();
    Reset = 1'b0;
    chk("reset hi",   {32'b0, bus.Hi},   64'd0);
    chk("reset lo",   {32'b0, bus.Lo},   64'd0);
    chk("reset busy", {63'b0, bus.Busy}, 64'd0);
    chk("reset done", {63'b0, bus.Done}, 64'd0);

    acc_m = 64'd0;
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].preset) begin
        write_hl(1'b1, 1'b0, vecs[i].hi0);
        write_hl(1'b0, 1'b1, vecs[i].lo0);
        chk($sformatf("v%0d preset", i), {bus.Hi, bus.Lo}, {vecs[i].hi0, vecs[i].lo0});
        acc_m = {vecs[i].hi0, vecs[i].lo0};
      end
      if (vecs[i].use_model) vecs[i].exp = ref_res(vecs[i].op, vecs[i].a, vecs[i].b, acc_m);
      acc_m = vecs[i].exp;
      exp_q.push_back(vecs[i].exp);
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      finish_op($sformatf("v%0d", i));
    end

    // Simultaneous mthi/mtlo, and a read in the write cycle still sees the old value.
    bus.HiWrite   = 1'b1;
    bus.LoWrite   = 1'b1;
    bus.WriteData = 32'hA5A5_0001;
    #1;
    chk("mthi pre-edge old", {bus.Hi, bus.Lo}, acc_m);
    tick();
    bus.HiWrite = 1'b0;
    bus.LoWrite = 1'b0;
    chk("both write", {bus.Hi, bus.Lo}, {32'hA5A5_0001, 32'hA5A5_0001});

    // Start wins over a same-cycle mtlo.
    bus.LoWrite   = 1'b1;
    bus.WriteData = 32'hDEAD_BEEF;
    exp_q.push_back(ref_res(2'b10, 32'd4, 32'd5, {32'hA5A5_0001, 32'hA5A5_0001}));
    start_op(2'b10, 32'd4, 32'd5);
    bus.LoWrite = 1'b0;
    finish_op("start_priority");

    // Requests during MUL are stalled and ignored.
    bus.HiLoRead = 1'b1;
    #1;
    chk("idle no stall", {63'b0, bus.Stall}, 64'd0);
    bus.HiLoRead = 1'b0;
    acc_m = {bus.Hi, bus.Lo};
    exp_q.push_back(ref_res(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 64'd0));
    start_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (3) tick();
    bus.HiLoRead = 1'b1;
    #1;
    chk("stall read", {63'b0, bus.Stall}, 64'd1);
    tick();
    bus.HiLoRead  = 1'b0;
    bus.HiWrite   = 1'b1;
    bus.WriteData = 32'h0000_1234;
    #1;
    chk("stall hiwrite", {63'b0, bus.Stall}, 64'd1);
    tick();
    bus.HiWrite = 1'b0;
    chk("hilo held", {bus.Hi, bus.Lo}, acc_m);
    bus.Start = 1'b1;
    bus.Op    = 2'b11;
    bus.A     = 32'd99;
    bus.B     = 32'd99;
    #1;
    chk("stall start", {63'b0, bus.Stall}, 64'd1);
    tick();
    bus.Start = 1'b0;
    chk("hilo held2", {bus.Hi, bus.Lo}, acc_m);
    begin : g_wait_stall_op
      int guard;
      guard = 0;
      while (!bus.Done && guard < 100) begin
        tick();
        guard++;
      end
      chk("stall op result", {bus.Hi, bus.Lo}, exp_q.pop_front());
      tick();
    end

    // Reset during iteration 10 abandons the operation.
    start_op(2'b00, 32'd1000, 32'd1000);
    repeat (9) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("mid reset busy", {63'b0, bus.Busy}, 64'd0);
    chk("mid reset hilo", {bus.Hi, bus.Lo}, 64'd0);
    begin : g_no_done
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (bus.Done) seen++;
      end
      chk("no done after reset", 64'(seen), 64'd0);
    end
    exp_q.push_back(64'd30);
    start_op(2'b00, 32'd5, 32'd6);
    finish_op("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hilo_mult_sequencer.md
# hilo_mult_sequencer

Multi-cycle multiply/accumulate sequencer that owns the HI and LO registers of the MIPS datapath. It executes mult, multu, madd and msub as a 32-iteration radix-2 shift-add operation. It services mthi/mtlo writes and mfhi/mflo reads, and asserts a stall to the pipeline while an operation is in flight. It sits beside the ALU in EX and is driven by the decode controller's HiWrite/LoWrite/Madd/Msub class of signals.

## Interface
- Clock is Clk. Reset is Reset: synchronous, active-high. Single clock domain.
- Parameter WIDTH, default 32: operand width. HI and LO are each WIDTH bits.
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous active-high reset
- Start  in  1  multiply-class instruction present in EX
- Op  in  2  operation: 00 mult (signed), 01 multu, 10 madd (signed), 11 msub (signed)
- A  in  WIDTH  rs operand
- B  in  WIDTH  rt operand
- HiWrite  in  1  mthi request
- LoWrite  in  1  mtlo request
- WriteData  in  WIDTH  data for mthi/mtlo
- HiLoRead  in  1  mfhi/mflo instruction present in EX
- Hi  out  WIDTH  HI register
- Lo  out  WIDTH  LO register
- Busy  out  1  operation in flight
- Done  out  1  one-cycle pulse when HI/LO are updated by an operation
- Stall  out  1  pipeline must hold EX and earlier stages

## Operation
- States: IDLE, MUL, FIN.
- IDLE, Start=1: latch Op.
  - For signed ops, latch Mcand=|A| and Mplier=|B| as unsigned WIDTH-bit values (|0x80000000| = 0x80000000), and set Neg = A[31]^B[31].
  - For multu, latch raw operands and set Neg=0.
  - Clear the 2*WIDTH-bit product register P and the iteration counter. Go to MUL.
- MUL: each cycle, if Mplier[0] then P[63:32] += Mcand, with the 33-bit carry kept. Then shift {carry,P} right 1 and shift Mplier right 1; counter++. After iteration 32 (counter wraps 31→0), go to FIN.
- FIN: R = Neg ? -P : P, computed mod 2^64. Then:
  - mult/multu: {Hi,Lo} ← R.
  - madd: {Hi,Lo} ← {Hi,Lo} + R.
  - msub: {Hi,Lo} ← {Hi,Lo} − R.
  - All arithmetic is 64-bit, mod 2^64, with no overflow flag.
  - Done=1 for one cycle, then go to IDLE.
- HiWrite/LoWrite in IDLE with Start=0: Hi/Lo ← WriteData on that edge. Both may be asserted together; both registers are then written.
- Start has priority over HiWrite/LoWrite in the same IDLE cycle; the writes are dropped.
- Start, HiWrite or LoWrite while Busy is ignored. The requester is stalled and re-presents the request.
- Stall = Busy & (Start | HiWrite | LoWrite | HiLoRead). This is combinational.
- Hi/Lo outputs always show the committed registers. They never show intermediate P.
- Reset (any state, including mid-MUL):
  - Hi=0, Lo=0, Busy=0, Done=0.
  - State=IDLE, the operation is abandoned, counter=0, P=0.

## Timing
- Start sampled at edge 0 → MUL.
- Iterations occur on edges 1..32. FIN occupies the cycle after edge 32.
- Hi/Lo are updated and Done is registered high at edge 33. Done falls at edge 34.
- Busy is registered and high after edges 0..32, i.e. for exactly 33 cycles. Busy is low after edge 33.
- A new Start is accepted on edge 33 only if Busy is already low. It is not, so the earliest back-to-back Start is accepted at edge 34. The result of the first operation is visible as the madd/msub accumulator operand.
- mfhi/mflo immediately after an operation: Stall is held through the cycle before edge 33. The read in the following cycle sees the new Hi/Lo.
- mthi/mtlo latency is 1 edge. No forwarding: reads in the same cycle see the old value.
- All outputs except Stall are registered.

## Test plan
- Reset, then mult A=0xFFFFFFFD (−3), B=7. Required: Busy high 33 cycles, Done pulse at edge 33, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- multu A=B=0xFFFFFFFF. Required: Hi=0xFFFFFFFE, Lo=0x00000001. Also mult A=B=0x80000000. Required: Hi=0x40000000, Lo=0x00000000.
- mthi 0x00000001 and mtlo 0x00000000, then madd A=2, B=3. Required: Hi=0x00000001, Lo=0x00000006. Then msub A=1, B=7 from that state. Required: Hi=0x00000000, Lo=0xFFFFFFFF.
- From Hi=Lo=0, msub A=1, B=1. Required: Hi=Lo=0xFFFFFFFF.
- During MUL, assert HiLoRead, then HiWrite with WriteData=0x1234, then Start. Required: Stall=1 in each of those cycles, Hi/Lo unchanged, and the operation result is unaffected.
- Assert Reset at iteration 10 of a mult. Required: next cycle Busy=0, Hi=Lo=0, Done never pulses. A subsequent mult 5×6 gives Lo=30, Hi=0.
